// File: rtl/muxn_rr.sv
// muxn_rr: N-channel registered selector with valid/ready handshakes.
//
// Several producers compete for one output register. In round-robin mode the
// search for a requester starts at a rotating pointer. In fixed-priority mode
// the lowest requesting index wins. At most one word per cycle is moved into
// the output register, and the register records which channel supplied it.
//
// Parameters
//   WIDTH  data bits per channel
//   NCH    number of input channels (>= 2)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid   per-channel request
//   in_data    channel i word at in_data[i*WIDTH +: WIDTH]
//   in_ready   one-hot (or zero) grant; channel i word accepted this cycle
//   out_valid  output register holds a word
//   out_ready  consumer takes the word this cycle
//   out_data   registered word
//   out_chan   index of the channel that supplied out_data
module muxn_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan
);

    logic [CW-1:0] ptr;
    logic          load;
    logic          gnt_any;
    logic [CW-1:0] gnt_idx;

    // ---- stage 0: combinational arbitration ----

    // The register can accept a word when it is empty or being drained now.
    assign load = ~out_valid | out_ready;

    // Both searches walk from the lowest-precedence candidate to the
    // highest-precedence one. The last hit therefore wins, so no early exit
    // is needed.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!reset && load) begin
            if (mode) begin
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = CW'(i);
                    end
                end
            end else begin
                for (int k = NCH - 1; k >= 0; k--) begin
                    // Wrap at NCH rather than 2**CW so non-power-of-two
                    // channel counts rotate correctly.
                    idx = int'(ptr) + k;
                    if (idx >= NCH) idx = idx - NCH;
                    if (in_valid[idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = CW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (gnt_any) in_ready[gnt_idx] = 1'b1;
    end

    // ---- stage 1: output register and rotation pointer ----

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_chan  <= gnt_idx;
            if (!mode) begin
                ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
            end
        end else if (out_valid && out_ready) begin
            // Drained with nothing to refill: data and channel are held.
            out_valid <= 1'b0;
        end
    end

endmodule
